// File: rtl/decode_sequencer.sv
// Decode sequencer: splits each fetch word into two instructions and hands them
// to the decoder in address order, stopping at the first all-zero instruction.
module decode_sequencer #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int COUNT_WIDTH    = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [63:0]                 entry_pc,
    input  logic                        flush,
    input  logic [63:0]                 flush_pc,
    input  logic                        in_valid,
    input  logic [BUS_DATA_WIDTH-1:0]   in_data,
    output logic                        in_ready,
    output logic                        inst_valid,
    output logic [BUS_DATA_WIDTH/2-1:0] inst,
    output logic [63:0]                 inst_pc,
    input  logic                        inst_ready,
    output logic                        halted,
    output logic [COUNT_WIDTH-1:0]      inst_count
);

    localparam int IW = BUS_DATA_WIDTH / 2;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_WORD,
        ISSUE_LO,
        ISSUE_HI,
        HALT
    } state_t;

    state_t                    state;
    logic [63:0]               pc;
    logic [BUS_DATA_WIDTH-1:0] word_buf;

    logic [IW-1:0]          buf_lo;
    logic [IW-1:0]          buf_hi;
    logic [IW-1:0]          in_lo;
    logic [IW-1:0]          in_hi;
    logic [63:0]            entry_aligned;
    logic [63:0]            flush_aligned;
    logic [COUNT_WIDTH-1:0] count_inc;
    logic                   unused_pc_low_bits;

    assign buf_lo        = word_buf[IW-1:0];
    assign buf_hi        = word_buf[BUS_DATA_WIDTH-1:IW];
    assign in_lo         = in_data[IW-1:0];
    assign in_hi         = in_data[BUS_DATA_WIDTH-1:IW];
    assign entry_aligned = {entry_pc[63:2], 2'b00};
    assign flush_aligned = {flush_pc[63:2], 2'b00};
    assign count_inc     = (inst_count == '1) ? inst_count : inst_count + 1'b1;

    // Addresses are always instruction aligned; the low two request bits are dropped.
    assign unused_pc_low_bits = ^{entry_pc[1:0], flush_pc[1:0]};

    assign inst_pc = pc;
    assign inst    = (state == ISSUE_HI) ? buf_hi : buf_lo;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the word buffer is reset with the control state so a word
            // discarded by reset can never reappear on inst after restart.
            state      <= IDLE;
            pc         <= '0;
            word_buf   <= '0;
            inst_count <= '0;
            halted     <= 1'b0;
            in_ready   <= 1'b0;
            inst_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking only, so every branch sees pre-edge values of
            // pc, inst_valid and inst_count regardless of statement order.
            case (state)
                IDLE, HALT: begin
                    if (start) begin
                        state      <= WAIT_WORD;
                        pc         <= entry_aligned;
                        inst_count <= '0;
                        halted     <= 1'b0;
                        in_ready   <= 1'b1;
                    end
                end

                WAIT_WORD: begin
                    if (flush) begin
                        pc       <= flush_aligned;
                        word_buf <= '0;
                    end else if (in_valid) begin
                        word_buf <= in_data;
                        in_ready <= 1'b0;
                        // A misaligned pc points at the high slot; the low one is skipped.
                        if (pc[2]) begin
                            state      <= ISSUE_HI;
                            inst_valid <= |in_hi;
                        end else begin
                            state      <= ISSUE_LO;
                            inst_valid <= |in_lo;
                        end
                    end
                end

                ISSUE_LO, ISSUE_HI: begin
                    if (flush) begin
                        state      <= WAIT_WORD;
                        pc         <= flush_aligned;
                        word_buf   <= '0;
                        inst_valid <= 1'b0;
                        in_ready   <= 1'b1;
                    end else if (!inst_valid) begin
                        // Slot is zero: stop with pc still pointing at it.
                        state  <= HALT;
                        halted <= 1'b1;
                    end else if (inst_ready) begin
                        pc         <= pc + 64'd4;
                        inst_count <= count_inc;
                        if (state == ISSUE_LO) begin
                            state      <= ISSUE_HI;
                            inst_valid <= |buf_hi;
                        end else begin
                            state      <= WAIT_WORD;
                            inst_valid <= 1'b0;
                            in_ready   <= 1'b1;
                        end
                    end
                end

                default: begin
                    state      <= IDLE;
                    inst_valid <= 1'b0;
                    in_ready   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decode_sequencer.sv
// Randomized scoreboard bench for decode_sequencer; a small instruction-stream
// model predicts issued instructions, addresses and counts.
module tb_decode_sequencer;

    localparam int BW = 64;
    localparam int CW = 3;  // small counter so saturation is reachable
    localparam logic [CW-1:0] CMAX = '1;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [63:0]   entry_pc;
    logic          flush;
    logic [63:0]   flush_pc;
    logic          in_valid;
    logic [BW-1:0] in_data;
    logic          in_ready;
    logic          inst_valid;
    logic [31:0]   inst;
    logic [63:0]   inst_pc;
    logic          inst_ready;
    logic          halted;
    logic [CW-1:0] inst_count;

    logic ready_force;
    logic rnd_ready;
    bit   rand_ready;
    assign inst_ready = rand_ready ? rnd_ready : ready_force;

    decode_sequencer #(.BUS_DATA_WIDTH(BW), .COUNT_WIDTH(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .entry_pc   (entry_pc),
        .flush      (flush),
        .flush_pc   (flush_pc),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_ready (inst_ready),
        .halted     (halted),
        .inst_count (inst_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0]   inst;
        logic [63:0]   pc;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    logic [63:0]   pc_m;
    logic [CW-1:0] cnt_m;
    bit            halt_m;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: walk the slots of a word from the current pc until a zero slot.
    task automatic model_word(input logic [63:0] w);
        logic [31:0] slot;
        for (int s = int'(pc_m[2]); s < 2; s++) begin
            slot = w[s*32 +: 32];
            if (slot == 32'h0) begin
                halt_m = 1'b1;
                break;
            end
            exp_q.push_back('{slot, pc_m, cnt_m});
            pc_m = pc_m + 64'd4;
            if (cnt_m != CMAX) cnt_m = cnt_m + 1'b1;
        end
    endtask

    // Monitor: pops the scoreboard on every effective handshake, checks hold rules.
    logic          prev_hold = 1'b0;
    logic [31:0]   prev_inst;
    logic [63:0]   prev_pc;
    exp_t          mon_e;

    always @(negedge clk) begin
        if (reset) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", inst_valid, 1'b1);
                check("hold_inst", inst, prev_inst);
                check("hold_pc", inst_pc, prev_pc);
            end
            if (inst_valid && inst_ready && !flush) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_issue: got inst 0x%0h at pc 0x%0h, expected none", inst, inst_pc);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("issue_inst", inst, mon_e.inst);
                    check("issue_pc", inst_pc, mon_e.pc);
                    check("issue_count", inst_count, mon_e.cnt);
                end
            end
            prev_hold = inst_valid && !inst_ready && !flush;
            prev_inst = inst;
            prev_pc   = inst_pc;
        end
    end

    initial begin
        rnd_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1 rnd_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        start    = 1'b0;
        flush    = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic do_start(input logic [63:0] e);
        start    = 1'b1;
        entry_pc = e;
        @(posedge clk);
        #1 start = 1'b0;
        pc_m   = {e[63:2], 2'b00};
        cnt_m  = '0;
        halt_m = 1'b0;
        exp_q.delete();
        check("start_in_ready", in_ready, 1'b1);
        check("start_halted", halted, 1'b0);
        check("start_count", inst_count, 0);
    endtask

    // Offers one word; push=0 leaves the model untouched (word will be discarded).
    task automatic send_word(input logic [63:0] w, input bit push);
        logic [31:0] first;
        bit          taken;
        first = pc_m[2] ? w[63:32] : w[31:0];
        if (push) model_word(w);
        in_data  = w;
        in_valid = 1'b1;
        taken    = 1'b0;
        for (int i = 0; i < 200 && !taken; i++) begin
            @(negedge clk);
            taken = in_ready;
        end
        if (!taken) begin
            check("in_ready_timeout", in_ready, 1'b1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("latency_inst_valid", inst_valid, first != 32'h0);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        check("drain_pending", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_halt();
        for (int i = 0; i < 50 && !halted; i++) begin
            @(posedge clk);
            #1;
        end
        check("halt_reached", halted, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int          nw;
        logic [31:0] lo;
        logic [31:0] hi;
        logic [63:0] e;

        reset = 1'b1; start = 1'b0; entry_pc = '0; flush = 1'b0; flush_pc = '0;
        in_valid = 1'b0; in_data = '0; ready_force = 1'b0; rand_ready = 1'b0;
        pc_m = '0; cnt_m = '0; halt_m = 1'b0;

        #2;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_inst_valid", inst_valid, 1'b0);
        check("rst_halted", halted, 1'b0);
        check("rst_count", inst_count, 0);
        check("rst_pc", inst_pc, 64'h0);
        check("rst_inst", inst, 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Idle ignores flush and never accepts words.
        flush = 1'b1; flush_pc = 64'h5000; in_valid = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0; in_valid = 1'b0;
        check("idle_in_ready", in_ready, 1'b0);
        check("idle_flush_ignored", inst_pc, 64'h0);

        // In-order issue of both slots.
        ready_force = 1'b1;
        do_start(64'h1000);
        send_word(64'h00500093_00000013, 1);
        wait_drain();
        check("inorder_in_ready", in_ready, 1'b1);
        check("inorder_count", inst_count, 2);

        // Misaligned entry skips the low slot.
        do_reset();
        do_start(64'h1004);
        send_word(64'hAAAAAAAB_CCCCCCCD, 1);
        wait_drain();
        check("misalign_count", inst_count, 1);
        check("misalign_in_ready", in_ready, 1'b1);

        // Halt on a zero slot; flush is then ignored.
        do_reset();
        do_start(64'h3000);
        send_word(64'h00000000_00100073, 1);
        wait_drain();
        wait_halt();
        check("halt_in_ready", in_ready, 1'b0);
        check("halt_inst_valid", inst_valid, 1'b0);
        check("halt_count", inst_count, cnt_m);
        check("halt_pc", inst_pc, pc_m);
        flush = 1'b1; flush_pc = 64'h7000;
        @(posedge clk);
        #1 flush = 1'b0;
        check("halt_flush_halted", halted, 1'b1);
        check("halt_flush_pc", inst_pc, pc_m);

        // Backpressure in ISSUE_LO; a start pulse mid-issue is ignored.
        ready_force = 1'b0;
        do_start(64'h4000);
        send_word(64'h11111111_22222222, 1);
        for (int i = 0; i < 5; i++) begin
            check("bp_inst", inst, 32'h22222222);
            check("bp_pc", inst_pc, 64'h4000);
            check("bp_in_ready", in_ready, 1'b0);
            check("bp_count", inst_count, 0);
            start = (i == 2); entry_pc = 64'h9990;
            @(posedge clk);
            #1 start = 1'b0;
        end
        ready_force = 1'b1;
        wait_drain();
        check("bp_final_count", inst_count, cnt_m);

        // Flush wins over a same-cycle instruction handshake.
        ready_force = 1'b0;
        send_word(64'h33333333_44444444, 0);
        ready_force = 1'b1; flush = 1'b1; flush_pc = 64'h2002;
        @(posedge clk);
        #1 flush = 1'b0; ready_force = 1'b0;
        pc_m = 64'h2000;
        check("flush_in_ready", in_ready, 1'b1);
        check("flush_inst_valid", inst_valid, 1'b0);
        check("flush_pc", inst_pc, pc_m);
        check("flush_count", inst_count, cnt_m);
        check("flush_buf_cleared", inst, 32'h0);
        ready_force = 1'b1;
        send_word(64'h55555555_66666666, 1);
        wait_drain();

        // Flush also wins over a same-cycle word handshake.
        in_valid = 1'b1; in_data = 64'hDEADBEEF_DEADBEEF; flush = 1'b1; flush_pc = 64'h2107;
        @(posedge clk);
        #1 in_valid = 1'b0; flush = 1'b0;
        pc_m = 64'h2104;
        check("flush_word_in_ready", in_ready, 1'b1);
        check("flush_word_valid", inst_valid, 1'b0);
        check("flush_word_pc", inst_pc, pc_m);

        // Reset mid-issue in ISSUE_HI clears outputs immediately; start needed after.
        ready_force = 1'b0;
        send_word(64'h77777777_88888888, 0);
        check("pre_rst_inst", inst, 32'h77777777);
        check("pre_rst_pc", inst_pc, 64'h2104);
        #1 reset = 1'b1;
        #1;
        check("midrst_inst_valid", inst_valid, 1'b0);
        check("midrst_in_ready", in_ready, 1'b0);
        check("midrst_inst", inst, 32'h0);
        check("midrst_pc", inst_pc, 64'h0);
        check("midrst_count", inst_count, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        in_valid = 1'b1; in_data = 64'h12345678_9ABCDEF0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("post_rst_in_ready", in_ready, 1'b0);
            check("post_rst_inst_valid", inst_valid, 1'b0);
        end
        in_valid = 1'b0;
        exp_q.delete();

        // pc wraps past 2^64 and the count saturates.
        ready_force = 1'b1;
        do_start(64'hFFFF_FFFF_FFFF_FFF8);
        for (int k = 0; k < 5; k++) send_word({32'(2 * k + 2), 32'(2 * k + 1)}, 1);
        wait_drain();
        check("sat_count", inst_count, cnt_m);
        check("wrap_pc", inst_pc, pc_m);

        // Randomized programs with random consumer backpressure.
        rand_ready = 1'b1;
        for (int p = 0; p < 40; p++) begin
            do_reset();
            e = {$urandom, $urandom};
            if (p % 8 == 0) e = 64'hFFFF_FFFF_FFFF_FFFC;
            do_start(e);
            nw = $urandom_range(1, 4);
            for (int w = 0; w < nw && !halt_m; w++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
                lo = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
                hi = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
                send_word({hi, lo}, 1);
            end
            wait_drain();
            if (halt_m) begin
                wait_halt();
                check("rnd_halt_in_ready", in_ready, 1'b0);
            end else begin
                check("rnd_in_ready", in_ready, 1'b1);
            end
            check("rnd_count", inst_count, cnt_m);
            check("rnd_pc", inst_pc, pc_m);
        end
        rand_ready = 1'b0;

        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
